// File: rtl/led_timer_pkg.sv
// led_timer_pkg: shared channel state encoding and mode constants for led_multi_timer.
package led_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/led_timer_channel.sv
// led_timer_channel: one programmable tick channel with periodic or one-shot mode.
module led_timer_channel
    import led_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] limit,
    input  logic             limit_mode,
    input  logic             enable,
    input  logic             strobe,
    output logic             tick,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             go;
    logic             term;

    assign go   = enable && strobe;
    assign term = state_q == ST_RUN && go && count_q == limit_q - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= MODE_PERIODIC;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    // A write always returns the channel to IDLE, overriding any terminal count.
    always_comb begin
        state_d = wr                                          ? ST_IDLE :
                  (state_q == ST_IDLE && go && limit_q != '0) ? ST_RUN  :
                  (term && mode_q == MODE_ONESHOT)            ? ST_DONE :
                  (state_q == ST_DONE && !enable)             ? ST_IDLE : state_q;
    end

    always_comb begin
        limit_d = wr ? limit : limit_q;
        mode_d  = wr ? limit_mode : mode_q;
        count_d = (wr || term || state_q != ST_RUN) ? '0 :
                  go ? count_q + WIDTH'(1) : count_q;
        tick_d  = !wr && term;
        busy_d  = state_d == ST_RUN;
    end

    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: rtl/led_multi_timer.sv
// led_multi_timer: NCH-channel programmable tick timer; optional shared prescaler
// enabled by defining LED_TIMER_PRESCALE_EN.
module led_multi_timer
    import led_timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH = 4,
`ifdef LED_TIMER_PRESCALE_EN
    parameter int PRESC_W = 8,
`endif
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit,
    input  logic             limit_mode,
    input  logic             limit_we,
    input  logic [SELW-1:0]  limit_sel,
    input  logic [NCH-1:0]   enable,
`ifdef LED_TIMER_PRESCALE_EN
    input  logic [PRESC_W-1:0] prescale,
`endif
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);

    logic strobe;

`ifdef LED_TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] pre_q, pre_d;

    // Comparing with >= lets a lowered prescale take effect at once instead of wrapping.
    always_comb begin
        strobe = pre_q >= prescale;
        pre_d  = strobe ? '0 : pre_q + PRESC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end
`else
    assign strobe = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        led_timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr         (limit_we && limit_sel == SELW'(i)),
            .limit      (limit),
            .limit_mode (limit_mode),
            .enable     (enable[i]),
            .strobe     (strobe),
            .tick       (tick[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_led_multi_timer.sv
// tb_led_multi_timer: scoreboard bench for led_multi_timer (NCH=4 and NCH=3 instances).
module tb_led_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] lim_v;
    logic [3:0]  en;
    logic [7:0]  presc;
    logic [3:0]  t4, b4;
    logic [2:0]  t3, b3;

    int checks = 0;
    int passed = 0;

    logic [13:0] exp_q[$];

    int lim[2][4];
    bit md[2][4];
    int left[2][4];
    bit spent[2][4];
    bit tk[2][4];
    int pc;

    always #5 clk = ~clk;

    led_multi_timer #(.WIDTH(16), .NCH(4)) dut4 (
        .clk(clk), .reset(reset), .limit(lim_v), .limit_mode(mode), .limit_we(we),
        .limit_sel(sel), .enable(en),
`ifdef LED_TIMER_PRESCALE_EN
        .prescale(presc),
`endif
        .tick(t4), .busy(b4)
    );

    led_multi_timer #(.WIDTH(16), .NCH(3)) dut3 (
        .clk(clk), .reset(reset), .limit(lim_v), .limit_mode(mode), .limit_we(we),
        .limit_sel(sel), .enable(en[2:0]),
`ifdef LED_TIMER_PRESCALE_EN
        .prescale(presc),
`endif
        .tick(t3), .busy(b3)
    );

    task automatic chk(input string n, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            chk("tick4", t4, e[13:10]);
            chk("busy4", b4, e[9:6]);
            chk("tick3", {1'b0, t3}, {1'b0, e[5:3]});
            chk("busy3", {1'b0, b3}, {1'b0, e[2:0]});
        end
    end

    // Reference: 'left' is enabled edges until the next tick (-1 when not running);
    // 'spent' marks a finished one-shot waiting for enable to drop.
    task automatic model();
        bit stb;
        logic [3:0] et4, eb4;
        logic [2:0] et3, eb3;
`ifdef LED_TIMER_PRESCALE_EN
        stb = pc >= int'(presc);
        pc = (reset || stb) ? 0 : pc + 1;
`else
        stb = 1'b1;
`endif
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < (u == 1 ? 3 : 4); c++) begin
                tk[u][c] = 1'b0;
                if (reset) begin
                    lim[u][c] = 0; md[u][c] = 0; left[u][c] = -1; spent[u][c] = 0;
                end else if (we && int'(sel) == c) begin
                    lim[u][c] = int'(lim_v); md[u][c] = mode; left[u][c] = -1; spent[u][c] = 0;
                end else if (left[u][c] < 0) begin
                    if (spent[u][c]) begin
                        if (!en[c]) spent[u][c] = 0;
                    end else if (en[c] && stb && lim[u][c] != 0) left[u][c] = lim[u][c];
                end else if (en[c] && stb) begin
                    left[u][c]--;
                    if (left[u][c] == 0) begin
                        tk[u][c] = 1'b1;
                        if (md[u][c]) begin left[u][c] = -1; spent[u][c] = 1; end
                        else left[u][c] = lim[u][c];
                    end
                end
            end
        for (int c = 0; c < 4; c++) begin
            et4[c] = tk[0][c];
            eb4[c] = left[0][c] >= 0;
        end
        for (int c = 0; c < 3; c++) begin
            et3[c] = tk[1][c];
            eb3[c] = left[1][c] >= 0;
        end
        exp_q.push_back({et4, eb4, et3, eb3});
    endtask

    task automatic cyc();
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic setw(input logic [1:0] s, input logic [15:0] l, input logic m);
        we = 1'b1; sel = s; lim_v = l; mode = m;
        cyc();
        we = 1'b0;
    endtask

    initial begin
        bit found;
        reset = 1'b1; we = 1'b0; mode = 1'b0; sel = '0; lim_v = '0; en = '0; presc = '0; pc = 0;
        run(2);
        reset = 1'b0;
        run(3);
        setw(2'd0, 16'd3, 1'b0);
        en[0] = 1'b1;
        run(12);
        setw(2'd1, 16'd5, 1'b1);
        setw(2'd2, 16'd4, 1'b0);
        en = 4'b1111;
        run(6);
        en[2] = 1'b0;
        run(2);
        en[2] = 1'b1;
        run(8);
        en[1] = 1'b0;
        run(1);
        en[1] = 1'b1;
        run(10);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(6);
        setw(2'd0, 16'd3, 1'b0);
        en[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (left[0][0] == 1) begin found = 1'b1; break; end
            cyc();
        end
        checks++;
        if (found) passed++;
        else $display("FAIL term_wait got=timeout exp=terminal cycle");
        setw(2'd0, 16'd3, 1'b0);
        run(8);
        setw(2'd3, 16'd2, 1'b0);
        run(6);
        for (int k = 0; k < 3000; k++) begin
            reset = $urandom_range(199) == 0;
            we    = $urandom_range(7) == 0;
            sel   = 2'($urandom_range(3));
            lim_v = 16'($urandom_range(6));
            mode  = 1'($urandom_range(1));
            for (int c = 0; c < 4; c++) en[c] = $urandom_range(3) != 0;
            if ($urandom_range(99) == 0) presc = 8'($urandom_range(3));
            cyc();
        end
        reset = 1'b0; we = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
